// File: rtl/mmt_rst_seq_if.sv
// Control/status bundle for the reset release sequencer: soft-reset request,
// per-domain release stalls, and the sequenced per-domain resets with status.
interface mmt_rst_seq_if #(
  parameter int NumDomains = 4
);
  logic                  sw_rst_req;
  logic [NumDomains-1:0] domain_hold;
  logic [NumDomains-1:0] rstn_out;
  logic                  seq_busy;
  logic                  seq_done;

  modport master (
    output sw_rst_req,
    output domain_hold,
    input  rstn_out,
    input  seq_busy,
    input  seq_done
  );

  modport slave (
    input  sw_rst_req,
    input  domain_hold,
    output rstn_out,
    output seq_busy,
    output seq_done
  );
endinterface

// File: rtl/mmt_rst_seq.sv
// Reset release sequencer: synchronizes rstn and releases domain resets in ascending order.
// Define MMT_RST_SEQ_REV_ASSERT_EN to make soft reset drop domains in reverse order.
module mmt_rst_seq #(
  parameter int NumDomains = 4,
  parameter int SyncStages = 2,
  parameter int GapCycles  = 16,
  parameter int HoldCycles = 8
) (
  input logic          clk,
  input logic          rstn,
  mmt_rst_seq_if.slave bus
);

  localparam int MaxCnt = (GapCycles > HoldCycles) ? GapCycles : HoldCycles;
  localparam int CntW   = $clog2(MaxCnt) + 1;
  localparam int IdxW   = (NumDomains > 1) ? $clog2(NumDomains) : 1;

  typedef enum logic [2:0] {
    RST,
    SEQ,
    DONE,
    DROP,
    ASSERT
  } state_t;

  state_t                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  pend_q, pend_d;
  logic [NumDomains-1:0] rout_q, rout_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // The state register leaving RST acts as the final synchronizer stage,
  // so only SyncStages-1 plain flops precede it.
  logic [SyncStages-2:0] sync_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= 1'b1;
      for (int i = 1; i < SyncStages - 1; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= RST;
      cnt_q   <= '0;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      rout_q  <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      rout_q  <= rout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    rout_d  = rout_q;

    case (state_q)
      RST: begin
        if (sync_q[SyncStages-2]) begin
          state_d = SEQ;
        end
      end

      SEQ: begin
        if (bus.sw_rst_req) begin
          pend_d = 1'b1;
        end
        if (!bus.domain_hold[idx_q]) begin
          if (cnt_q == CntW'(GapCycles - 1)) begin
            rout_d[idx_q] = 1'b1;
            cnt_d         = '0;
            if (idx_q == IdxW'(NumDomains - 1)) begin
              idx_d   = '0;
              state_d = DONE;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      // A request that arrived while sequencing is honoured here, one cycle after DONE.
      DONE: begin
        if (bus.sw_rst_req || pend_q) begin
          pend_d = 1'b0;
          cnt_d  = '0;
`ifdef MMT_RST_SEQ_REV_ASSERT_EN
          rout_d[NumDomains-1] = 1'b0;
          idx_d                = IdxW'(NumDomains - 1);
          state_d              = (NumDomains > 1) ? DROP : ASSERT;
`else
          rout_d  = '0;
          idx_d   = '0;
          state_d = ASSERT;
`endif
        end
      end

`ifdef MMT_RST_SEQ_REV_ASSERT_EN
      DROP: begin
        if (bus.sw_rst_req) begin
          pend_d = 1'b1;
        end
        if (cnt_q == CntW'(GapCycles - 1)) begin
          rout_d[idx_q - 1'b1] = 1'b0;
          idx_d                = idx_q - 1'b1;
          cnt_d                = '0;
          if (idx_q == IdxW'(1)) begin
            state_d = ASSERT;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif

      ASSERT: begin
        if (bus.sw_rst_req) begin
          pend_d = 1'b1;
        end
        if (cnt_q == CntW'(HoldCycles - 1)) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = SEQ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = RST;
      end
    endcase

    busy_d = (state_d != DONE);
    done_d = (state_d == DONE);
  end

  assign bus.rstn_out = rout_q;
  assign bus.seq_busy = busy_q;
  assign bus.seq_done = done_q;

endmodule

// File: tb/tb_mmt_rst_seq.sv
// Directed bench for mmt_rst_seq: tables of timed stimulus/expectations plus an async-reset sequence.
module tb_mmt_rst_seq;

  typedef struct {
    int         at;
    logic [3:0] hold;
    logic       req;
    logic [3:0] exp_out;
    logic       exp_busy;
    logic       exp_done;
    string      name;
  } vec_t;

  logic clk;
  logic rstn;
  int   cyc;
  int   errors;
  int   checks;
  vec_t vecs[$];

  mmt_rst_seq_if #(.NumDomains(4)) bus ();

  mmt_rst_seq #(
    .NumDomains(4),
    .SyncStages(2),
    .GapCycles (16),
    .HoldCycles(8)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic add(input int at, input logic [3:0] hold, input logic req,
                     input logic [3:0] exp_out, input logic exp_busy,
                     input logic exp_done, input string name);
    vec_t v;
    v.at = at; v.hold = hold; v.req = req;
    v.exp_out = exp_out; v.exp_busy = exp_busy; v.exp_done = exp_done;
    v.name = name;
    vecs.push_back(v);
  endtask

  task automatic check_output(input logic [3:0] exp_out, input logic exp_busy,
                              input logic exp_done, input string name);
    checks++;
    if (bus.rstn_out !== exp_out || bus.seq_busy !== exp_busy || bus.seq_done !== exp_done) begin
      errors++;
      $display("[TB] FAIL %s @cyc %0d: got out=%b busy=%b done=%b, expected out=%b busy=%b done=%b",
               name, cyc, bus.rstn_out, bus.seq_busy, bus.seq_done, exp_out, exp_busy, exp_done);
    end
  endtask

  // Checks each record once the DUT has taken edge 'at', then drives its inputs for the next edges.
  task automatic apply_stimulus();
    foreach (vecs[k]) begin
      while (cyc < vecs[k].at) step();
      check_output(vecs[k].exp_out, vecs[k].exp_busy, vecs[k].exp_done, vecs[k].name);
      bus.domain_hold = vecs[k].hold;
      bus.sw_rst_req  = vecs[k].req;
    end
    vecs.delete();
  endtask

  // Leaves time at #1 after T0 with cyc = 0.
  task automatic reset_and_sync();
    bus.sw_rst_req  = 1'b0;
    bus.domain_hold = '0;
    @(negedge clk);
    rstn = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_output(4'b0000, 1'b1, 1'b0, "reset_state");
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check_output(4'b0000, 1'b1, 1'b0, "sync_edge1");
    @(posedge clk);
    #1;
    cyc = 0;
  endtask

  task automatic load_plain_release();
    add(0,  4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, "t0");
    add(15, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, "d0_before");
    add(16, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b0, "d0_rise");
    add(31, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b0, "d1_before");
    add(32, 4'b0000, 1'b0, 4'b0011, 1'b1, 1'b0, "d1_rise");
    add(48, 4'b0000, 1'b0, 4'b0111, 1'b1, 1'b0, "d2_rise");
    add(63, 4'b0000, 1'b0, 4'b0111, 1'b1, 1'b0, "d3_before");
    add(64, 4'b0000, 1'b0, 4'b1111, 1'b0, 1'b1, "all_released");
    add(65, 4'b0000, 1'b0, 4'b1111, 1'b0, 1'b1, "done_stays");
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    rstn   = 1'b0;
    bus.sw_rst_req  = 1'b0;
    bus.domain_hold = '0;

    // Plain release, then a soft reset from DONE.
    reset_and_sync();
    load_plain_release();
    add(70, 4'b0000, 1'b1, 4'b1111, 1'b0, 1'b1, "done_idle");
`ifdef MMT_RST_SEQ_REV_ASSERT_EN
    add(71,  4'b0000, 1'b0, 4'b0111, 1'b1, 1'b0, "rev_d3_drop");
    add(86,  4'b0000, 1'b0, 4'b0111, 1'b1, 1'b0, "rev_d2_before");
    add(87,  4'b0000, 1'b0, 4'b0011, 1'b1, 1'b0, "rev_d2_drop");
    add(103, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b0, "rev_d1_drop");
    add(119, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, "rev_d0_drop");
    add(142, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, "rev_hold_end");
    add(143, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b0, "rev_d0_rise");
    add(190, 4'b0000, 1'b0, 4'b0111, 1'b1, 1'b0, "rev_d3_before");
    add(191, 4'b0000, 1'b0, 4'b1111, 1'b0, 1'b1, "rev_done");
`else
    add(71,  4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, "sw_all_drop");
    add(94,  4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, "sw_d0_before");
    add(95,  4'b0000, 1'b0, 4'b0001, 1'b1, 1'b0, "sw_d0_rise");
    add(142, 4'b0000, 1'b0, 4'b0111, 1'b1, 1'b0, "sw_d3_before");
    add(143, 4'b0000, 1'b0, 4'b1111, 1'b0, 1'b1, "sw_done");
`endif
    apply_stimulus();

    // Hold on the next domain stalls release; holds on other domains are ignored.
    reset_and_sync();
    add(16, 4'b1011, 1'b0, 4'b0001, 1'b1, 1'b0, "hold_start");
    add(26, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b0, "hold_end");
    add(41, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b0, "held_d1_before");
    add(42, 4'b0000, 1'b0, 4'b0011, 1'b1, 1'b0, "held_d1_rise");
    add(58, 4'b0000, 1'b0, 4'b0111, 1'b1, 1'b0, "held_d2_rise");
    add(73, 4'b0000, 1'b0, 4'b0111, 1'b1, 1'b0, "held_d3_before");
    add(74, 4'b0000, 1'b0, 4'b1111, 1'b0, 1'b1, "held_done");
    apply_stimulus();

    // Two mid-sequence requests collapse into one soft reset after a 1-cycle DONE.
    reset_and_sync();
    add(19, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b0, "mid_req");
    add(20, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b0, "mid_req_no_effect");
    add(29, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b0, "mid_req2");
    add(30, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b0, "mid_req2_no_effect");
    add(64, 4'b0000, 1'b0, 4'b1111, 1'b0, 1'b1, "pend_done");
`ifdef MMT_RST_SEQ_REV_ASSERT_EN
    add(65,  4'b0000, 1'b0, 4'b0111, 1'b1, 1'b0, "pend_serviced");
    add(137, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b0, "pend_d0_rise");
    add(185, 4'b0000, 1'b0, 4'b1111, 1'b0, 1'b1, "pend_redone");
    add(186, 4'b0000, 1'b0, 4'b1111, 1'b0, 1'b1, "pend_collapsed");
`else
    add(65,  4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, "pend_serviced");
    add(89,  4'b0000, 1'b0, 4'b0001, 1'b1, 1'b0, "pend_d0_rise");
    add(137, 4'b0000, 1'b0, 4'b1111, 1'b0, 1'b1, "pend_redone");
    add(138, 4'b0000, 1'b0, 4'b1111, 1'b0, 1'b1, "pend_collapsed");
`endif
    apply_stimulus();

    // Async rstn pulse mid-sequence with a pending request: clears without a clock edge.
    reset_and_sync();
    add(35, 4'b0000, 1'b1, 4'b0011, 1'b1, 1'b0, "pre_abort_req");
    add(36, 4'b0000, 1'b0, 4'b0011, 1'b1, 1'b0, "pre_abort");
    add(40, 4'b0000, 1'b0, 4'b0011, 1'b1, 1'b0, "abort_point");
    apply_stimulus();
    #2;
    rstn = 1'b0;
    #1;
    check_output(4'b0000, 1'b1, 1'b0, "async_clear");
    repeat (2) @(posedge clk);
    #1;
    check_output(4'b0000, 1'b1, 1'b0, "held_in_reset");
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cyc = 0;
    load_plain_release();
    apply_stimulus();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
